// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: load-use hazard detection, bubble insertion, branch flush and global hold.
// Define IDEX_BUBBLE_CNT_EN to add a bubble_cnt output counting inserted bubbles.
module id_ex_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [DATA_W-1:0]   id_pc,
  input  logic [REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]   id_rt,
  input  logic [REG_AW-1:0]   id_wr_reg,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic [DATA_W-1:0]   id_rs_data,
  input  logic [DATA_W-1:0]   id_rt_data,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_mem_to_reg,
  input  logic                id_alu_src,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  output logic                stall,
  output logic                ex_valid,
  output logic [DATA_W-1:0]   ex_pc,
  output logic [DATA_W-1:0]   ex_rs_data,
  output logic [DATA_W-1:0]   ex_rt_data,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [REG_AW-1:0]   ex_rs,
  output logic [REG_AW-1:0]   ex_rt,
  output logic [REG_AW-1:0]   ex_wr_reg,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_mem_to_reg,
  output logic                ex_alu_src,
  output logic [ALU_OP_W-1:0] ex_alu_op
`ifdef IDEX_BUBBLE_CNT_EN
  ,
  output logic [31:0]         bubble_cnt
`endif
);

  typedef struct packed {
    logic                valid;
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
    logic [DATA_W-1:0]   imm;
    logic [REG_AW-1:0]   rs;
    logic [REG_AW-1:0]   rt;
    logic [REG_AW-1:0]   wr_reg;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
  } ex_slot_t;

  ex_slot_t ex_q, ex_d;
  logic     load_use;
  logic     bubble;

  always_comb begin
    load_use = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.wr_reg != '0) &&
               ((id_uses_rs && (id_rs == ex_q.wr_reg)) ||
                (id_uses_rt && (id_rt == ex_q.wr_reg)));
    // Gated by reset so stall is low while the core is held in reset.
    stall  = reset && (hold || (load_use && !flush));
    bubble = !hold && (flush || load_use);
  end

  always_comb begin
    ex_d = ex_q;
    if (!hold) begin
      if (flush || load_use) begin
        ex_d = '0;
      end else begin
        ex_d.valid      = id_valid;
        ex_d.pc         = id_pc;
        ex_d.rs_data    = id_rs_data;
        ex_d.rt_data    = id_rt_data;
        ex_d.imm        = id_imm;
        ex_d.rs         = id_rs;
        ex_d.rt         = id_rt;
        ex_d.wr_reg     = id_wr_reg;
        ex_d.reg_write  = id_valid && id_reg_write;
        ex_d.mem_read   = id_valid && id_mem_read;
        ex_d.mem_write  = id_valid && id_mem_write;
        ex_d.mem_to_reg = id_valid && id_mem_to_reg;
        ex_d.alu_src    = id_valid && id_alu_src;
        ex_d.alu_op     = id_valid ? id_alu_op : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_rs_data    = ex_q.rs_data;
  assign ex_rt_data    = ex_q.rt_data;
  assign ex_imm        = ex_q.imm;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_wr_reg     = ex_q.wr_reg;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_alu_op     = ex_q.alu_op;

`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bubble_cnt_q <= '0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a slot-level reference model checked every cycle plus literal spot checks.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, hold, flush, id_valid;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_wr_reg;
  logic        id_uses_rs, id_uses_rt;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
  logic [3:0]  id_alu_op;
  logic        stall, ex_valid;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_wr_reg;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [3:0]  ex_alu_op;
`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .ALU_OP_W(4)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt), .id_wr_reg(id_wr_reg),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_wr_reg(ex_wr_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op)
`ifdef IDEX_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  // Reference: what instruction occupies the EX slot, and how many bubbles went in.
  typedef struct {
    bit          v;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs, rt, wr;
    bit          rw, mr, mw, m2r, as;
    logic [3:0]  op;
  } slot_t;

  slot_t       m;
  logic [31:0] m_bub = 0;

  function automatic slot_t empty_slot();
    slot_t s;
    s.v = 0; s.pc = 0; s.a = 0; s.b = 0; s.imm = 0; s.rs = 0; s.rt = 0; s.wr = 0;
    s.rw = 0; s.mr = 0; s.mw = 0; s.m2r = 0; s.as = 0; s.op = 0;
    return s;
  endfunction

  // ID instruction reads a register the load in EX has not yet produced.
  function automatic bit needs_load_result(slot_t ex);
    bit reads_rs, reads_rt;
    if (!(ex.v && ex.mr) || ex.wr == 0 || !id_valid) return 0;
    reads_rs = id_uses_rs && (id_rs == ex.wr);
    reads_rt = id_uses_rt && (id_rt == ex.wr);
    return reads_rs || reads_rt;
  endfunction

  function automatic bit model_stall();
    if (!reset) return 0;
    if (hold) return 1;
    return needs_load_result(m) && !flush;
  endfunction

  function automatic slot_t advance(slot_t ex);
    slot_t s;
    if (hold) return ex;
    if (flush || needs_load_result(ex)) return empty_slot();
    s = empty_slot();
    s.v = id_valid; s.pc = id_pc; s.a = id_rs_data; s.b = id_rt_data; s.imm = id_imm;
    s.rs = id_rs; s.rt = id_rt; s.wr = id_wr_reg;
    if (id_valid) begin
      s.rw = id_reg_write; s.mr = id_mem_read; s.mw = id_mem_write;
      s.m2r = id_mem_to_reg; s.as = id_alu_src; s.op = id_alu_op;
    end
    return s;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m     <= empty_slot();
      m_bub <= 0;
    end else begin
      if (!hold && (flush || needs_load_result(m))) m_bub <= m_bub + 1;
      m <= advance(m);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", stall, model_stall());
      chk("ex_valid", ex_valid, m.v);
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rs_data", ex_rs_data, m.a);
      chk("ex_rt_data", ex_rt_data, m.b);
      chk("ex_imm", ex_imm, m.imm);
      chk("ex_rs", ex_rs, m.rs);
      chk("ex_rt", ex_rt, m.rt);
      chk("ex_wr_reg", ex_wr_reg, m.wr);
      chk("ex_reg_write", ex_reg_write, m.rw);
      chk("ex_mem_read", ex_mem_read, m.mr);
      chk("ex_mem_write", ex_mem_write, m.mw);
      chk("ex_mem_to_reg", ex_mem_to_reg, m.m2r);
      chk("ex_alu_src", ex_alu_src, m.as);
      chk("ex_alu_op", ex_alu_op, m.op);
      if (!ex_valid) chk("bubble_inv", {ex_reg_write, ex_mem_read, ex_mem_write}, 3'b000);
`ifdef IDEX_BUBBLE_CNT_EN
      chk("bubble_cnt", bubble_cnt, m_bub);
`endif
    end
  end

  task automatic clr_id();
    id_valid = 0; id_pc = 0; id_rs = 0; id_rt = 0; id_wr_reg = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    id_alu_src = 0; id_alu_op = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_lw(input logic [31:0] pc, input logic [4:0] wr);
    clr_id();
    id_valid = 1; id_pc = pc; id_rs = 5'd29; id_uses_rs = 1; id_wr_reg = wr;
    id_imm = 32'h10; id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
    id_alu_src = 1; id_alu_op = 4'h2; id_rs_data = 32'h1000;
  endtask

  task automatic set_add(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                         input bit urs, input bit urt, input logic [31:0] a, input logic [31:0] b);
    clr_id();
    id_valid = 1; id_pc = pc; id_rs = rs; id_rt = rt; id_wr_reg = 5'd10;
    id_uses_rs = urs; id_uses_rt = urt; id_rs_data = a; id_rt_data = b;
    id_reg_write = 1; id_alu_op = 4'h2;
  endtask

  initial begin
    reset = 0; hold = 0; flush = 0;
    clr_id();
    tick(); tick();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_stall", stall, 0);
    chk_en = 1;
    reset = 1;
    tick();

    // T2: lw $8 then dependent add on rs: exactly one bubble.
    set_lw(32'h100, 5'd8);
    tick();
    chk("t2_lw_in_ex", ex_mem_read, 1);
    set_add(32'h104, 5'd8, 5'd9, 1, 1, 32'h11, 32'h22);
    #1 chk("t2_stall", stall, 1);
    tick();
    chk("t2_bubble", ex_valid, 0);
    id_rs_data = 32'h55;
    #1 chk("t2_stall_drop", stall, 0);
    tick();
    chk("t2_add_valid", ex_valid, 1);
    chk("t2_add_rs_data", ex_rs_data, 32'h55);

    // rt-side hazard
    set_lw(32'h108, 5'd9);
    tick();
    set_add(32'h10C, 5'd3, 5'd9, 1, 1, 32'h1, 32'h2);
    #1 chk("rt_stall", stall, 1);
    tick();
    id_rt_data = 32'h77;
    tick();
    chk("rt_add_rt_data", ex_rt_data, 32'h77);

    // T3a: load to $0 never stalls.
    set_lw(32'h110, 5'd0);
    tick();
    set_add(32'h114, 5'd0, 5'd4, 1, 1, 32'h0, 32'h4);
    #1 chk("t3_r0_stall", stall, 0);
    tick();
    chk("t3_r0_captured", ex_pc, 32'h114);

    // T3b: matching rs but not used.
    set_lw(32'h118, 5'd8);
    tick();
    set_add(32'h11C, 5'd8, 5'd4, 0, 1, 32'h8, 32'h4);
    #1 chk("t3_nouse_stall", stall, 0);
    tick();
    chk("t3_nouse_captured", ex_valid, 1);

    // T4: flush beats load-use.
    set_lw(32'h120, 5'd8);
    tick();
    set_add(32'h124, 5'd8, 5'd8, 1, 1, 32'h8, 32'h8);
    id_mem_write = 1;
    flush = 1;
    #1 chk("t4_stall", stall, 0);
    tick();
    flush = 0;
    chk("t4_bubble", ex_valid, 0);
    chk("t4_mem_write", ex_mem_write, 0);

    // T5: hold freezes EX even with flush and changing ID.
    clr_id();
    id_valid = 1; id_pc = 32'h200; id_rs = 5'd1; id_rt = 5'd2; id_mem_write = 1;
    id_rs_data = 32'hAA; id_rt_data = 32'hBB; id_alu_src = 1; id_imm = 32'h4;
    tick();
    chk("t5_sw_pc", ex_pc, 32'h200);
    hold = 1; flush = 1;
    for (int i = 0; i < 3; i++) begin
      id_pc = 32'h300 + 32'(i * 4);
      id_rs_data = 32'(i);
      #1 chk("t5_hold_stall", stall, 1);
      tick();
      chk("t5_frozen_pc", ex_pc, 32'h200);
    end
    hold = 0;
    tick();
    flush = 0;
    chk("t5_flush_bubble", ex_valid, 0);

    // hold during a load-use keeps the load in EX.
    set_lw(32'h400, 5'd7);
    tick();
    set_add(32'h404, 5'd7, 5'd0, 1, 0, 32'h7, 32'h0);
    hold = 1;
    tick();
    chk("hold_lw_kept", ex_mem_read, 1);
    hold = 0;
    tick();
    tick();
    chk("hold_lu_add", ex_pc, 32'h404);

    // T6: invalid ID slot carries no controls.
    clr_id();
    id_valid = 0; id_reg_write = 1; id_mem_write = 1; id_mem_read = 1; id_pc = 32'h500;
    tick();
    chk("t6_valid", ex_valid, 0);
    chk("t6_reg_write", ex_reg_write, 0);
    chk("t6_mem_write", ex_mem_write, 0);

    // T1: async reset clears EX mid-cycle.
    set_add(32'h600, 5'd1, 5'd2, 1, 1, 32'h1, 32'h2);
    tick();
    chk("t1_pre_reg_write", ex_reg_write, 1);
    hold = 1;
    reset = 0;
    #1;
    chk("t1_valid", ex_valid, 0);
    chk("t1_reg_write", ex_reg_write, 0);
    chk("t1_pc", ex_pc, 0);
    chk("t1_stall", stall, 0);
    tick();
    hold = 0;
    reset = 1;
    tick();
    tick();
    chk("post_rst_capture", ex_pc, 32'h600);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
